// File: rtl/sram_uart_dump.sv
// Streams a region of external SRAM out of the UART TX pin as raw 8N1 bytes.
// Each 16-bit word goes out as its high byte, then its low byte, with no idle gap between the two.
module sram_uart_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Initialize,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done,
  output logic [2:0]  State_debug
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'((READ_LATENCY > 1) ? READ_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    S_DU_IDLE, S_DU_ISSUE, S_DU_WAIT, S_DU_CAPTURE,
    S_DU_TX_HIGH, S_DU_TX_LOW, S_DU_DONE
  } du_state_t;

  du_state_t      state;
  logic [17:0]    remaining;
  logic [7:0]     low_byte_buf;
  logic [7:0]     shift_reg;
  logic [BW-1:0]  baud_cnt;
  logic [3:0]     bit_idx;
  logic [LW-1:0]  lat_cnt;
  logic           advance;
  logic           frame_bit;
  logic           baud_end;

  assign SRAM_we_n   = 1'b1;
  assign State_debug = state;
  assign baud_end    = (baud_cnt == BAUD_LAST);

  // Bit 0 is the start bit, bits 1..8 are data LSB first, bit 9 is the stop bit.
  always_comb begin
    frame_bit = shift_reg[0];
    if (bit_idx == 4'd0) frame_bit = 1'b0;
    else if (bit_idx == 4'd9) frame_bit = 1'b1;
  end

  // Start is a request that is accepted only in S_DU_IDLE; Busy is high for as
  // long as the block owns the SRAM port, and Done pulses once on completion.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_DU_IDLE;
      SRAM_address <= '0;
      UART_TX_O    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      remaining    <= '0;
      low_byte_buf <= '0;
      shift_reg    <= '0;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      lat_cnt      <= '0;
      advance      <= 1'b0;
    end else if (Initialize) begin
      state        <= S_DU_IDLE;
      SRAM_address <= '0;
      UART_TX_O    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      remaining    <= '0;
      low_byte_buf <= '0;
      shift_reg    <= '0;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      lat_cnt      <= '0;
      advance      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_DU_IDLE: begin
          UART_TX_O <= 1'b1;
          if (Start) begin
            if (Word_count == 18'd0) begin
              state <= S_DU_DONE;
            end else begin
              remaining    <= Word_count;
              SRAM_address <= Start_address;
              Busy         <= 1'b1;
              state        <= S_DU_ISSUE;
            end
          end
        end
        S_DU_ISSUE: begin
          UART_TX_O <= 1'b1;
          lat_cnt   <= LAT_LOAD;
          state     <= (READ_LATENCY > 1) ? S_DU_WAIT : S_DU_CAPTURE;
        end
        S_DU_WAIT: begin
          UART_TX_O <= 1'b1;
          if (lat_cnt <= LW'(1)) state <= S_DU_CAPTURE;
          else lat_cnt <= lat_cnt - LW'(1);
        end
        S_DU_CAPTURE: begin
          UART_TX_O    <= 1'b1;
          low_byte_buf <= SRAM_read_data[7:0];
          shift_reg    <= SRAM_read_data[15:8];
          baud_cnt     <= '0;
          bit_idx      <= '0;
          state        <= S_DU_TX_HIGH;
        end
        S_DU_TX_HIGH: begin
          UART_TX_O <= frame_bit;
          if (!baud_end) begin
            baud_cnt <= baud_cnt + BW'(1);
          end else begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx   <= '0;
              shift_reg <= low_byte_buf;
              state     <= S_DU_TX_LOW;
            end else begin
              if (bit_idx != 4'd0) shift_reg <= shift_reg >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_DU_TX_LOW: begin
          if (advance) begin
            // Idle-high cycle after the stop bit in which the next address is presented.
            UART_TX_O    <= 1'b1;
            advance      <= 1'b0;
            SRAM_address <= SRAM_address + 18'd1;
            state        <= S_DU_ISSUE;
          end else begin
            UART_TX_O <= frame_bit;
            if (!baud_end) begin
              baud_cnt <= baud_cnt + BW'(1);
            end else begin
              baud_cnt <= '0;
              if (bit_idx == 4'd9) begin
                bit_idx   <= '0;
                remaining <= remaining - 18'd1;
                if (remaining == 18'd1 || SRAM_address == 18'h3FFFF) state <= S_DU_DONE;
                else advance <= 1'b1;
              end else begin
                if (bit_idx != 4'd0) shift_reg <= shift_reg >> 1;
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end
        end
        S_DU_DONE: begin
          UART_TX_O <= 1'b1;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= S_DU_IDLE;
        end
        default: begin
          UART_TX_O <= 1'b1;
          state     <= S_DU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_dump.sv
// Directed bench for sram_uart_dump: SRAM model with 2-cycle latency, a TX-line
// recorder/decoder, and a byte scoreboard fed with hand-computed expectations.
module tb_sram_uart_dump;
  localparam int CPB = 4;
  localparam int RL  = 2;
  localparam int LOG_MAX = 2048;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Initialize = 1'b0;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data = '0;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;
  logic [2:0]  State_debug;

  sram_uart_dump #(.CLKS_PER_BIT(CPB), .READ_LATENCY(RL)) dut (
    .Clock(Clock), .Resetn(Resetn), .Initialize(Initialize), .Start(Start),
    .Start_address(Start_address), .Word_count(Word_count),
    .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
    .SRAM_we_n(SRAM_we_n), .UART_TX_O(UART_TX_O), .Busy(Busy), .Done(Done),
    .State_debug(State_debug)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SRAM model: address registered once, data registered once -> 2-cycle latency
  function automatic logic [15:0] mem_word(input logic [17:0] a);
    case (a)
      18'd76800:  mem_word = 16'hA55A;
      18'd10:     mem_word = 16'h0102;
      18'd11:     mem_word = 16'h0304;
      18'd12:     mem_word = 16'h0506;
      18'h3FFFE:  mem_word = 16'hBEEF;
      18'h3FFFF:  mem_word = 16'hCAFE;
      default:    mem_word = a[15:0] ^ 16'h1234;
    endcase
  endfunction

  logic [17:0] addr_d1 = '0;
  always @(posedge Clock) begin
    addr_d1        <= SRAM_address;
    SRAM_read_data <= mem_word(addr_d1);
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_eq({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // line recorder: sample k is taken at the negedge after edge E0+k
  logic        tx_log[LOG_MAX];
  logic        busy_log[LOG_MAX];
  logic [17:0] addr_log[LOG_MAX];
  int          starts[$];
  int          done_at, done_cnt, busy_seen, we_bad, log_len;

  task automatic start_dump(input logic [17:0] sa, input logic [17:0] wc);
    @(negedge Clock);
    Start_address = sa;
    Word_count    = wc;
    Start         = 1'b1;
    @(negedge Clock);
    Start         = 1'b0;
    Start_address = 18'(32'($urandom_range(0, 262143)));
    Word_count    = 18'(32'($urandom_range(0, 9)));
  endtask

  task automatic record(input int max);
    done_at = -1; done_cnt = 0; busy_seen = 0; we_bad = 0; log_len = 0;
    for (int k = 0; k < max && k < LOG_MAX; k++) begin
      if (k > 0) @(negedge Clock);
      tx_log[k]   = UART_TX_O;
      busy_log[k] = Busy;
      addr_log[k] = SRAM_address;
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      busy_seen += int'(Busy === 1'b1);
      we_bad    += int'(SRAM_we_n !== 1'b1);
      log_len = k + 1;
      if (done_at >= 0 && k >= done_at + 4) break;
    end
    check_eq("done_seen", 32'(done_at >= 0), 1);
  endtask

  task automatic decode();
    int i;
    logic [7:0] b;
    starts.delete();
    i = 0;
    while (i + 10 * CPB <= log_len) begin
      if (tx_log[i] === 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = tx_log[i + (j + 1) * CPB + CPB / 2];
        check_eq("stop_bit", 32'(tx_log[i + 9 * CPB + CPB / 2]), 1);
        got_q.push_back(b);
        starts.push_back(i);
        i += 10 * CPB;
      end else begin
        i++;
      end
    end
  endtask

  int bad;

  initial begin
    // reset state
    repeat (3) @(negedge Clock);
    check_eq("rst_addr", 32'(SRAM_address), 0);
    check_eq("rst_we_n", 32'(SRAM_we_n), 1);
    check_eq("rst_tx", 32'(UART_TX_O), 1);
    check_eq("rst_busy", 32'(Busy), 0);
    check_eq("rst_done", 32'(Done), 0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    // single word 0xA55A at 76800
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    start_dump(18'd76800, 18'd1);
    record(400);
    decode();
    check_eq("w1_done_at", done_at, 84);
    check_eq("w1_done_cnt", done_cnt, 1);
    check_eq("w1_first_start", starts.size() > 0 ? starts[0] : -1, 4);
    check_eq("w1_tx_before_start", 32'(tx_log[3]), 1);
    check_eq("w1_busy_83", 32'(busy_log[83]), 1);
    check_eq("w1_busy_84", 32'(busy_log[84]), 0);
    bad = 0;
    for (int k = 0; k < log_len; k++) bad += int'(addr_log[k] !== 18'd76800);
    check_eq("w1_addr_stable", bad, 0);
    check_eq("w1_we_n", we_bad, 0);
    check_bytes("w1");

    // three words from address 10
    for (int v = 1; v <= 6; v++) exp_q.push_back(8'(v));
    start_dump(18'd10, 18'd3);
    record(600);
    decode();
    check_eq("w3_done_at", done_at, 252);
    for (int j = 1; j < starts.size(); j++)
      check_eq("w3_gap", starts[j] - starts[j - 1] - 10 * CPB, (j % 2 == 0) ? 4 : 0);
    for (int j = 0; 2 * j < starts.size(); j++)
      check_eq("w3_addr", 32'(addr_log[starts[2 * j]]), 10 + j);
    check_bytes("w3");

    // saturation at the top of the address space
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    start_dump(18'h3FFFE, 18'd5);
    record(800);
    decode();
    check_eq("sat_done_at", done_at, 168);
    check_eq("sat_addr", 32'(addr_log[done_at >= 0 ? done_at : 0]), 32'h3FFFF);
    check_bytes("sat");

    // zero-length dump
    start_dump(18'd76800, 18'd0);
    record(50);
    decode();
    check_eq("z_done_at", done_at, 1);
    check_eq("z_busy_seen", busy_seen, 0);
    bad = 0;
    for (int k = 0; k < log_len; k++) bad += int'(tx_log[k] !== 1'b1);
    check_eq("z_tx_high", bad, 0);
    check_bytes("z");

    // Initialize during data bit 3 of the first byte
    start_dump(18'd76800, 18'd1);
    repeat (21) @(negedge Clock);
    check_eq("init_pre_tx", 32'(UART_TX_O), 0);
    Initialize = 1'b1;
    @(negedge Clock);
    Initialize = 1'b0;
    check_eq("init_tx", 32'(UART_TX_O), 1);
    check_eq("init_busy", 32'(Busy), 0);
    check_eq("init_done", 32'(Done), 0);
    check_eq("init_addr", 32'(SRAM_address), 0);
    bad = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge Clock);
      bad += int'(Done === 1'b1) + int'(UART_TX_O !== 1'b1);
    end
    check_eq("init_quiet", bad, 0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    start_dump(18'd76800, 18'd1);
    record(400);
    decode();
    check_eq("init_redo_done_at", done_at, 84);
    check_bytes("init_redo");

    // Start re-pulsed while busy, then asynchronous reset mid-byte
    start_dump(18'd10, 18'd3);
    repeat (9) @(negedge Clock);
    Start_address = 18'd5;
    Word_count    = 18'd0;
    Start         = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (19) @(negedge Clock);
    check_eq("rep_busy", 32'(Busy), 1);
    check_eq("rep_addr", 32'(SRAM_address), 10);
    check_eq("rep_done", 32'(Done), 0);
    #2;
    Resetn = 1'b0;
    #1;
    check_eq("arst_tx", 32'(UART_TX_O), 1);
    check_eq("arst_busy", 32'(Busy), 0);
    check_eq("arst_done", 32'(Done), 0);
    check_eq("arst_addr", 32'(SRAM_address), 0);
    check_eq("arst_we_n", 32'(SRAM_we_n), 1);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_uart_dump.md
# sram_uart_dump

Streams a contiguous region of the external SRAM back out over the UART TX pin as raw bytes, high byte of each 16-bit word first. It is the read-back counterpart of the UART-to-SRAM loader: the loader fills SRAM from the PC, this block returns SRAM contents (decoded image or loaded bitstream) to the PC for checking. It owns the SRAM port only while `Busy`, and contains its own 8N1 bit serializer.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200 baud).
- `READ_LATENCY`, 2: cycles from `SRAM_address` valid to `SRAM_read_data` valid.
- `Clock`  in  1  system clock (50 MHz).
- `Resetn`  in  1  asynchronous, active-low reset.
- `Initialize`  in  1  synchronous abort/clear; has priority over all other inputs.
- `Start`  in  1  begin a dump; sampled only in S_DU_IDLE.
- `Start_address`  in  18  first SRAM word address; captured on accepted `Start`.
- `Word_count`  in  18  number of 16-bit words to send; captured on accepted `Start`.
- `SRAM_address`  out  18  read address.
- `SRAM_read_data`  in  16  read data from the SRAM controller.
- `SRAM_we_n`  out  1  write enable, active-low; constant 1.
- `UART_TX_O`  out  1  serial output, idle high.
- `Busy`  out  1  high from accepted `Start` until the final stop bit ends.
- `Done`  out  1  one-cycle pulse when a dump completes.

## Operation
- Reset / `Initialize`: `SRAM_address`=0, `SRAM_we_n`=1, `UART_TX_O`=1, `Busy`=0, `Done`=0, all counters 0, state S_DU_IDLE. If `Initialize` arrives mid-byte, the byte is truncated and the line returns high on the next edge.
- States: S_DU_IDLE, S_DU_ISSUE, S_DU_WAIT, S_DU_CAPTURE, S_DU_TX_HIGH, S_DU_TX_LOW, S_DU_DONE.
- S_DU_IDLE: on `Start`=1 with `Word_count`=0, go to S_DU_DONE and send nothing. With `Word_count`>0, latch the count, set `SRAM_address`<=`Start_address`, `Busy`<=1, and go to S_DU_ISSUE.
- S_DU_ISSUE: the address is stable on the bus. Load the latency counter and go to S_DU_WAIT.
- S_DU_WAIT: stay `READ_LATENCY`-1 cycles, then go to S_DU_CAPTURE.
- S_DU_CAPTURE: register `SRAM_read_data` into a 16-bit word buffer, load the shift register with `[15:8]`, and go to S_DU_TX_HIGH.
- Byte frame: start bit 0, then data bits LSB first, then stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles. A baud counter counts 0..`CLKS_PER_BIT`-1, and a bit index counts 0..9.
- S_DU_TX_HIGH: at the end of the stop bit, load `[7:0]` and go to S_DU_TX_LOW. The next start bit follows with no idle gap.
- S_DU_TX_LOW: at the end of the stop bit, decrement the remaining count.
  - Count reaches 0: go to S_DU_DONE.
  - `SRAM_address`=18'h3FFFF: go to S_DU_DONE; the address saturates and does not wrap.
  - Otherwise: `SRAM_address`+1, then go to S_DU_ISSUE.
- S_DU_DONE: `Done`=1 for one cycle, `Busy`<=0, then return to S_DU_IDLE.
- `Start` while `Busy` is ignored.
- `Start_address`/`Word_count` changes after capture have no effect.

## Timing
- Edge E0 samples `Start`; `SRAM_address` is valid after E0.
- `SRAM_read_data` is captured at edge E0+1+`READ_LATENCY`.
- `UART_TX_O` falls (start bit) on edge E0+2+`READ_LATENCY`.
- Per word: 20×`CLKS_PER_BIT` cycles of frame time.
- Inter-word idle-high gap: exactly `READ_LATENCY`+2 cycles (address increment, ISSUE, WAIT, CAPTURE).
- Total dump of N words: `Done` pulses N×(20×`CLKS_PER_BIT`+`READ_LATENCY`+2) cycles after E0.
- `Busy` falls on the same edge `Done` rises.
- `Word_count`=0: `Done` pulses on edge E0+1 and `UART_TX_O` never leaves 1.
- `UART_TX_O` and `Done` are driven from flops (glitch-free).

## Test plan
- Sim params `CLKS_PER_BIT`=4, `READ_LATENCY`=2. SRAM model: 76800→16'hA55A. `Start_address`=76800, `Word_count`=1 → line shows frame 0x5A-reversed-order bits for byte 0xA5 then 0x5A (LSB first). `Done` pulses at E0+84. `SRAM_address` stays 76800.
- `Word_count`=3 from address 10, data 0x0102/0x0304/0x0506 → decoded bytes 01 02 03 04 05 06. Exactly 4 idle cycles between words, 0 within a word. Addresses 10, 11, 12.
- `Start_address`=18'h3FFFE, `Word_count`=5 → 2 words sent. `SRAM_address` saturates at 3FFFF. `Done` fires after the second word.
- `Word_count`=0 → `Done` at E0+1, `Busy` never rises, `UART_TX_O` constantly 1.
- `Initialize` asserted during data bit 3 of the first byte → next edge `UART_TX_O`=1, `Busy`=0, no `Done`. A subsequent `Start` dumps correctly.
- `Start` re-pulsed while `Busy`; `Resetn` low mid-byte → the re-pulse is ignored. Reset immediately forces all outputs to reset values; `SRAM_we_n`=1 throughout.
